// File: rtl/log_pipe_fifo.sv
// log_pipe_fifo: logger-to-host pipe buffer. A 2^DEPTH_LOG2 x 16 circular
// buffer sits between a logger that writes and a host pipe-out that reads.
// The buffer reports an almost-full flag with a margin, so the logger can
// absorb the writes it makes after seeing full. It also keeps sticky
// overflow and underflow flags.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-high reset
//   clear_in      synchronous flush: empties the FIFO and clears sticky flags
//   write_in      write strobe, one word per asserted cycle
//   data_in       write word, sampled with write_in
//   read_in       read strobe, one word per asserted cycle
//   data_out      registered read word
//   valid_out     one-cycle pulse: data_out holds a newly read word
//   full_out      almost-full (free words <= FULL_MARGIN)
//   empty_out     no words stored
//   count_out     words stored, 0..DEPTH
//   overflow_out  sticky: a write was dropped
//   underflow_out sticky: a read hit an empty FIFO
module log_pipe_fifo #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_in,
  input  logic                  write_in,
  input  logic [15:0]           data_in,
  input  logic                  read_in,
  output logic [15:0]           data_out,
  output logic                  valid_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic [DEPTH_LOG2:0]   count_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = CNT_W'(DEPTH);
  // full_out asserts once count reaches DEPTH-FULL_MARGIN (clamped at 0)
  localparam logic [DEPTH_LOG2:0] FULL_THRESH =
    CNT_W'((FULL_MARGIN >= DEPTH) ? 0 : DEPTH - FULL_MARGIN);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_miss;
  logic [DEPTH_LOG2:0]   count_next;

  always_comb begin
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    wr_drop    = 1'b0;
    rd_miss    = 1'b0;
    count_next = count_out;
    if (!clear_in) begin
      rd_acc  = read_in && (count_out != '0);
      rd_miss = read_in && (count_out == '0);
      // A write into a full buffer is still accepted when a read frees a slot in the same cycle
      wr_acc  = write_in && ((count_out != DEPTH_CNT) || rd_acc);
      wr_drop = write_in && !wr_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_out + CNT_W'(1);
        2'b01:   count_next = count_out - CNT_W'(1);
        default: count_next = count_out;
      endcase
    end else begin
      count_next = '0;
    end
  end

  // Storage has no reset; pointers and count guard against stale reads
  always_ff @(posedge clk_in) begin
    if (wr_acc && !rst_in) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wptr          <= '0;
      rptr          <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      full_out      <= 1'b0;
      empty_out     <= 1'b1;
      count_out     <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else if (clear_in) begin
      wptr          <= '0;
      rptr          <= '0;
      valid_out     <= 1'b0;
      full_out      <= 1'b0;
      empty_out     <= 1'b1;
      count_out     <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        // Read-before-write: with wptr==rptr at full, the oldest word is returned
        data_out <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      count_out <= count_next;
      empty_out <= (count_next == '0);
      full_out  <= (count_next >= FULL_THRESH);
      if (wr_drop) begin
        overflow_out <= 1'b1;
      end
      if (rd_miss) begin
        underflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log_pipe_fifo.sv
module tb_log_pipe_fifo;

  localparam int unsigned DL2 = 4;
  localparam int unsigned FM  = 4;
  localparam int unsigned DEP = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          clear_in = 1'b0;
  logic          write_in = 1'b0;
  logic [15:0]   data_in = '0;
  logic          read_in = 1'b0;
  logic [15:0]   data_out;
  logic          valid_out;
  logic          full_out;
  logic          empty_out;
  logic [DL2:0]  count_out;
  logic          overflow_out;
  logic          underflow_out;

  log_pipe_fifo #(.DEPTH_LOG2(DL2), .FULL_MARGIN(FM)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
    .write_in(write_in), .data_in(data_in), .read_in(read_in),
    .data_out(data_out), .valid_out(valid_out), .full_out(full_out),
    .empty_out(empty_out), .count_out(count_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, sticky flags, last read word
  logic [15:0] mq[$];
  logic [15:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_last = '0;
  endtask

  task automatic check_state();
    chk("count", 32'(count_out), 32'(mq.size()));
    chk("empty", 32'(empty_out), 32'(mq.size() == 0));
    chk("full", 32'(full_out), 32'((DEP - mq.size()) <= FM));
    chk("overflow", 32'(overflow_out), 32'(m_ovf));
    chk("underflow", 32'(underflow_out), 32'(m_unf));
    chk("valid", 32'(valid_out), 32'(m_valid));
    if (!m_valid) chk("data_hold", 32'(data_out), 32'(m_last));
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
    bit rd, wr;
    @(negedge clk_in);
    write_in = w; data_in = d; read_in = r; clear_in = c;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    end else begin
      rd = r && (mq.size() > 0);
      wr = w && ((mq.size() < DEP) || rd);
      if (r && !rd) m_unf = 1'b1;
      if (w && !wr) m_ovf = 1'b1;
      m_valid = rd;
      if (rd) begin
        m_last = mq.pop_front();
        sb.push_back(m_last);
      end
      if (wr) mq.push_back(d);
    end
    @(posedge clk_in);
    #1;
    check_state();
  endtask

  // Scoreboard monitor: every presented word must be the next expected one
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (valid_out) begin
        if (sb.size() == 0) chk("unexpected_valid", 32'(valid_out), 32'(0));
        else chk("read_data", 32'(data_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic fill_overflow_to7();
    while (mq.size() < DEP) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    while (mq.size() > 7) step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_valid", 32'(valid_out), 32'(0));
    chk("rst_full", 32'(full_out), 32'(0));
    chk("rst_empty", 32'(empty_out), 32'(1));
    chk("rst_count", 32'(count_out), 32'(0));
    chk("rst_ovf", 32'(overflow_out), 32'(0));
    chk("rst_unf", 32'(underflow_out), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_values();
    @(negedge clk_in);
    rst_in = 1'b0;

    // Basic order and one-cycle read latency
    step(1'b1, 16'h2323, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Fill to full, simultaneous read/write at full, then a dropped write
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    step(1'b1, 16'hA5A5, 1'b1, 1'b0);
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b0);

    // Async reset mid-cycle with count=7 and overflow set
    while (mq.size() > 7) step(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk_in);
    write_in = 1'b0; read_in = 1'b0; clear_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;

    // Underflow with simultaneous write into empty; first write lands after reset
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Clear with count=7 and overflow set; strobes in the clear cycle are ignored
    fill_overflow_to7();
    step(1'b1, 16'hCAFE, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1);

    // Randomised stream with interleaved reads; wraps the pointers many times
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 99) < 50), 1'b0);
    end
    while (mq.size() > 0) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
